// File: rtl/regfile_dump_reader.sv
// Readback engine: walks an inclusive, wrapping register range through one
// read port and streams (address, data, last) words over valid/ready.
module regfile_dump_reader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rd_reg,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_end_q;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              w_handshake;

    assign w_handshake = r_out_valid && out_ready;

    // cur_addr only changes on the way into READ, so it doubles as the
    // read-port address and naturally holds its value in other states.
    assign rd_reg    = r_cur_addr;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE);
    // Gated by abort so an abort landing in DONE suppresses the pulse.
    assign done      = (r_state == S_DONE) && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_end_q     <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur_addr <= start_addr;
                        r_end_q    <= end_addr;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_out_data  <= rd_data;
                        r_out_addr  <= r_cur_addr;
                        r_out_last  <= (r_cur_addr == r_end_q);
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_state <= S_DONE;
                        end else begin
                            // NUM_REGS == 2**ADDR_W, so overflow is the wrap.
                            r_cur_addr <= r_cur_addr + ADDR_W'(1);
                            r_state    <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: register-file model plus a queue
// scoreboard of expected (addr, data, last) words checked at each handshake.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  start_addr = '0;
    logic [4:0]  end_addr = '0;
    logic [4:0]  rd_reg;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } word_t;

    word_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_reg];

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rd_reg     (rd_reg),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input logic [4:0] s, input logic [4:0] e);
        int n;
        int a;
        word_t w;
        n = ((int'(e) - int'(s) + 32) % 32) + 1;
        for (int i = 0; i < n; i++) begin
            a   = (int'(s) + i) % 32;
            w.a = 5'(a);
            w.d = regs[a];
            w.l = (i == n - 1);
            exp_q.push_back(w);
        end
    endtask

    // mode 0: out_ready always high; mode 1: random ready with a 10-cycle stall.
    // abort_word>0 aborts while that word is offered (with out_ready high).
    task automatic run_dump(input logic [4:0] s, input logic [4:0] e, input int mode,
                            input int abort_word, input bit start_abort, input int exp_last_hs);
        int    hs;
        int    first_v;
        int    last_hs;
        int    done_iter;
        int    exp_n;
        bit    prev_stall;
        bit    aborted;
        word_t prev_w;
        word_t w;
        logic [4:0] prev_rd;

        exp_n = ((int'(e) - int'(s) + 32) % 32) + 1;
        push_words(s, e);
        @(negedge clk);
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        abort      = start_abort;
        out_ready  = (mode == 0);
        hs = 0; first_v = -1; last_hs = -1; done_iter = -1;
        prev_stall = 1'b0; aborted = 1'b0; prev_w = '0; prev_rd = '0;

        for (int iter = 1; iter <= 400; iter++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (mode == 0)                     out_ready = 1'b1;
            else if (iter >= 6 && iter < 16)  out_ready = 1'b0;
            else                               out_ready = 1'($urandom_range(0, 1));
            if (iter == 1) chk("busy_in_read", busy, 1);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_payload", {out_addr, out_data, out_last}, prev_w);
                chk("stall_rd_reg", rd_reg, prev_rd);
            end
            if (out_valid && first_v < 0) first_v = iter;
            if (done) begin
                done_iter = iter;
                break;
            end
            if (out_valid && out_ready) begin
                if (hs + 1 == abort_word) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_valid_drop", out_valid, 0);
                    chk("abort_busy", busy, 0);
                    aborted = 1'b1;
                    break;
                end
                hs++;
                chk("queue_has_word", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("word", {out_addr, out_data, out_last}, w);
                end
                last_hs = iter;
            end
            prev_stall = out_valid && !out_ready;
            prev_w     = {out_addr, out_data, out_last};
            prev_rd    = rd_reg;
        end

        chk("first_valid_latency", first_v, 2);
        if (aborted) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("abort_no_done", done, 0);
            end
            chk("abort_words_before", hs, abort_word - 1);
            exp_q.delete();
        end else begin
            chk("word_count", hs, exp_n);
            chk("done_one_after_last", done_iter, last_hs + 1);
            chk("queue_empty", exp_q.size(), 0);
            if (exp_last_hs > 0) chk("cycles_to_last_accept", last_hs, exp_last_hs);
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            exp_q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);

        repeat (2) @(negedge clk);
        chk("reset_outputs", {rd_reg, out_addr, out_data, out_valid, out_last, busy, done}, 0);
        rst = 1'b0;

        run_dump(5'd0, 5'd31, 0, 0, 1'b0, 64);

        // start with abort also high in IDLE: dump must still run.
        regs[7] = 32'hDEAD_BEEF;
        run_dump(5'd7, 5'd7, 0, 0, 1'b1, 2);

        run_dump(5'd30, 5'd1, 0, 0, 1'b0, 8);

        run_dump(5'd3, 5'd12, 1, 0, 1'b0, 0);

        run_dump(5'd0, 5'd31, 0, 5, 1'b0, 0);
        run_dump(5'd0, 5'd31, 0, 0, 1'b0, 64);

        // Asynchronous reset landing between edges while a word is held.
        @(negedge clk);
        start_addr = 5'd0;
        end_addr   = 5'd31;
        start      = 1'b1;
        out_ready  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {rd_reg, out_addr, out_data, out_valid, out_last, busy, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_dump(5'd3, 5'd5, 0, 0, 1'b0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential readback engine for the 32x32 register file.
- On a start pulse, walks a register-address range through one read port, captures each word and streams (address, data) pairs out over a valid/ready handshake.
- Used for debug dumps and end-of-run result extraction: the reader counterpart to the write-side traffic the register file normally sees.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers. Must equal 2**ADDR_W; address arithmetic wraps modulo NUM_REGS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  terminate the dump in progress.
- start_addr  input  ADDR_W  first register to read; sampled with start.
- end_addr  input  ADDR_W  last register to read, inclusive; sampled with start.
- rd_reg  output  ADDR_W  address driven to the register-file read port.
- rd_data  input  DATA_W  combinational read data for rd_reg.
- out_valid  output  1  out_addr/out_data/out_last are valid.
- out_ready  input  1  consumer accepts the current word.
- out_addr  output  ADDR_W  register index of the current word.
- out_data  output  DATA_W  captured register contents.
- out_last  output  1  current word is the final word of the dump.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - rd_reg, out_addr, out_data, cur_addr and end_q all 0.
  - out_valid, out_last, busy and done all 0.
- States: IDLE, READ, HOLD, DONE.
- IDLE:
  - start=1 latches cur_addr<=start_addr and end_q<=end_addr, then goes to READ.
  - start in any other state is ignored.
- READ (exactly 1 cycle):
  - rd_reg=cur_addr.
  - At the clock edge: out_data<=rd_data, out_addr<=cur_addr, out_last<=(cur_addr==end_q), out_valid<=1, then go to HOLD.
- HOLD:
  - out_valid held high. out_data, out_addr and out_last are stable until the handshake.
  - Handshake is out_valid && out_ready in the same cycle. out_valid deasserts on the next edge.
  - After the handshake with out_last=0: cur_addr<=cur_addr+1, wrapping 31->0, then go to READ.
  - After the handshake with out_last=1: go to DONE.
- DONE (1 cycle): done=1, then go to IDLE. busy is 0 from IDLE onward.
- Throughput is at most one word per 2 cycles. Latency from start to the first out_valid is 2 cycles.
- Word count is ((end_addr - start_addr) mod NUM_REGS) + 1.
  - start_addr==end_addr gives exactly 1 word.
  - start_addr > end_addr wraps through register 31 to register 0.
- rd_reg is meaningful only in READ. It holds its last value elsewhere.
- Data coherence is per word only: each word is a snapshot of rd_data at its READ edge. A write to a register before that register's READ cycle is visible in the dump; a write after it is not.
- Register 0 is read like any other register (the register file returns its value). There is no special casing.
- abort=1 in READ, HOLD or DONE:
  - Next state is IDLE.
  - out_valid<=0, out_last<=0.
  - No done pulse, including when abort arrives in DONE.
  - abort takes priority over a same-cycle handshake.
  - abort in IDLE has no effect.
- start and abort both high in IDLE: abort is ignored and the dump starts.
- The consumer may hold out_ready high continuously. out_ready while out_valid=0 has no effect.

Test Plan:
- Full dump: preload reg i with 32'hA000_0000+i, start with 0..31, out_ready=1 → 32 words, out_addr 0..31 with matching data, out_last only on addr 31, done 1 cycle after the last handshake, 64 cycles from start to last accept.
- Single word: start_addr=end_addr=7, reg7=32'hDEAD_BEEF → one word {7, DEADBEEF, last=1}, then done.
- Wrap: start 30..1 → words for addresses 30, 31, 0, 1 in order, last on 1, 4 handshakes total.
- Backpressure: out_ready toggled with a random pattern (including a 10-cycle stall) → out_valid and payload stable through the stall, no word dropped or duplicated, rd_reg unchanged during HOLD.
- Abort mid-dump at the 5th word in HOLD with out_ready=1 in the same cycle → word not counted, out_valid=0 next cycle, no done; a new start then runs a full dump correctly.
- Async reset asserted mid-HOLD between clock edges → all outputs 0 immediately; busy=0; a start after reset release behaves normally.
